// File: rtl/data_mem_arbiter_pkg.sv
// Shared sizing defaults, FSM state encoding and port identifiers for the data memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 512;

  // INIT zero-fills the memory, IDLE arbitrates, ACCESS is the single memory cycle.
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  // Port 0 is the execution core, port 1 the keypad/display loader.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way round-robin winner select from the raw requests and the last-served port.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module dm_rr_pick
  import data_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic vld,
  output logic win
);

  // A lone requester wins outright; on a tie the port not served last wins.
  always_comb begin
    vld = req0 | req1;
    win = PORT0;
    if (req1 && (!req0 || (last == PORT0))) begin
      win = PORT1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data memory port between two requesters, zero-filling the memory after reset.
// Latency: GNT one cycle after REQ is sampled, ACK/RDATA on the following edge; one access per 2 cycles.
// Backpressure: REQ is held by the requester until GNT; the arbiter ignores requests during INIT and ACCESS.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              ACK0,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA0,
  output logic [DATA_W-1:0] RDATA1,
  output logic              READY,
  output logic              MEM_EN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_IN,
  input  logic [DATA_W-1:0] MEM_OUT
);

  // The clear pointer carries one extra bit so "all words written" is a plain compare.
  localparam logic [ADDR_W:0] CLR_END = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CLR_ONE = (ADDR_W+1)'(1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W:0]   clr_ptr_q, clr_ptr_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_in_q, mem_in_d;
  logic              ready_q, ready_d;

  logic              pick_vld;
  logic              pick_win;

  dm_rr_pick u_pick (
    .req0 (REQ0),
    .req1 (REQ1),
    .last (last_q),
    .vld  (pick_vld),
    .win  (pick_win)
  );

  // Next-state logic: clear sweep, arbitration and the access completion cycle.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    last_d     = last_q;
    win_d      = win_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;
    mem_in_d   = mem_in_q;
    ready_d    = ready_q;

    case (state_q)
      ST_INIT: begin
        if (clr_ptr_q == CLR_END) begin
          state_d  = ST_IDLE;
          ready_d  = 1'b1;
          mem_en_d = 1'b0;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = clr_ptr_q[ADDR_W-1:0];
          mem_in_d   = '0;
          clr_ptr_d  = clr_ptr_q + CLR_ONE;
        end
      end

      ST_IDLE: begin
        // Without a clear sweep, READY comes up on the first edge after reset.
        ready_d  = 1'b1;
        mem_en_d = 1'b0;
        if (pick_vld) begin
          win_d   = pick_win;
          state_d = ST_ACCESS;
          if (pick_win == PORT1) begin
            mem_en_d   = WE1;
            mem_addr_d = ADDR1;
            mem_in_d   = WDATA1;
            gnt1_d     = 1'b1;
          end else begin
            mem_en_d   = WE0;
            mem_addr_d = ADDR0;
            mem_in_d   = WDATA0;
            gnt0_d     = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        // A write already committed on the falling edge; a read samples the memory now.
        if (win_q == PORT1) begin
          ack1_d = 1'b1;
          if (!mem_en_q) rdata1_d = MEM_OUT;
        end else begin
          ack0_d = 1'b1;
          if (!mem_en_q) rdata0_d = MEM_OUT;
        end
        mem_en_d = 1'b0;
        last_d   = win_q;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  // All arbiter state; reset drops MEM_EN at once so a pending write never reaches memory.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      clr_ptr_q  <= '0;
      last_q     <= PORT1;
      win_q      <= PORT0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      last_q     <= last_d;
      win_q      <= win_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_in_q   <= mem_in_d;
      ready_q    <= ready_d;
    end
  end

  assign GNT0     = gnt0_q;
  assign GNT1     = gnt1_q;
  assign ACK0     = ack0_q;
  assign ACK1     = ack1_q;
  assign RDATA0   = rdata0_q;
  assign RDATA1   = rdata1_q;
  assign READY    = ready_q;
  assign MEM_EN   = mem_en_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_IN   = mem_in_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural 512x16 memory attached.
// Latency: n/a.
// Backpressure: requesters hold REQ until GNT is observed.
module tb_data_mem_arbiter;

  localparam int AW    = 9;
  localparam int DW    = 16;
  localparam int DEPTH = 512;

  logic          CLK;
  logic          RST;
  logic          REQ0, REQ1, WE0, WE1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] WDATA0, WDATA1;
  logic          GNT0, GNT1, ACK0, ACK1, READY, MEM_EN;
  logic [DW-1:0] RDATA0, RDATA1, MEM_IN, MEM_OUT;
  logic [AW-1:0] MEM_ADDR;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1),
    .RDATA0(RDATA0), .RDATA1(RDATA1), .READY(READY),
    .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR), .MEM_IN(MEM_IN), .MEM_OUT(MEM_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: writes on the falling edge, combinational read.
  logic [DW-1:0] mem [DEPTH];
  bit            preload_go = 1'b0;
  always @(negedge CLK) begin
    if (preload_go) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h5A5A;
    end else if (MEM_EN) begin
      mem[MEM_ADDR] <= MEM_IN;
    end
  end
  assign MEM_OUT = mem[MEM_ADDR];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle;
    REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({GNT0, GNT1, ACK0, ACK1, READY, MEM_EN}), 32'd0);
    chk({tag, "_rdata"}, 32'({RDATA1, RDATA0}), 32'd0);
    chk({tag, "_membus"}, 32'({MEM_ADDR, MEM_IN}), 32'd0);
  endtask

  // Hold reset a few cycles (optionally dirtying memory), check outputs, release after an edge.
  task automatic hold_reset(input bit preload);
    RST = 1'b0;
    #1;
    if (preload) begin
      @(posedge CLK); preload_go = 1'b1;
      @(posedge CLK); preload_go = 1'b0;
    end
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("rst");
    RST = 1'b1;
  endtask

  // Edges 1..DEPTH sweep addresses 0..DEPTH-1 with zeros; edge DEPTH+1 raises READY.
  task automatic run_clear;
    int bad;
    int nz;
    bad = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      step;
      if (!(MEM_EN === 1'b1 && int'(MEM_ADDR) == k - 1 && MEM_IN === '0 &&
            READY === 1'b0 && GNT0 === 1'b0 && GNT1 === 1'b0)) bad++;
    end
    chk("clear_cycles_bad", 32'(bad), 32'd0);
    step;
    chk("ready_rise", 32'(READY), 32'd1);
    chk("clear_done_mem_en", 32'(MEM_EN), 32'd0);
    chk("no_gnt_at_ready", 32'({GNT1, GNT0}), 32'd0);
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 16'h0000) nz++;
    chk("mem_zeroed_words", 32'(nz), 32'd0);
  endtask

  typedef struct {
    bit            r0;
    bit            w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    bit            r1;
    bit            w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    bit            win;
    bit            rd;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl [8];

  // Random-phase reference state.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] m_rd [2];
  bit            pend [2];
  bit            c_we [2];
  logic [AW-1:0] c_addr [2];
  logic [DW-1:0] c_dat [2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int            bad;
    int            idx;
    bit            exp_g;
    bit            req_e0, req_e1, busy, w, m_last, prev_read, prev_port;
    logic [1:0]    exp_gv, prev_g;
    logic [DW-1:0] prev_val;

    // Each entry starts in IDLE and expects a grant on the first edge.
    tbl[0] = '{1'b1, 1'b1, 9'h00A, 16'hFF85, 1'b1, 1'b0, 9'h00A, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h00A, 16'h0000, 1'b1, 1'b1, 16'hFF85};
    tbl[2] = '{1'b1, 1'b1, 9'h010, 16'h1111, 1'b1, 1'b1, 9'h011, 16'h2222, 1'b0, 1'b0, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 9'h011, 16'h0000, 1'b1, 1'b1, 9'h011, 16'h2222, 1'b1, 1'b0, 16'h0000};
    tbl[4] = '{1'b1, 1'b0, 9'h011, 16'h0000, 1'b1, 1'b0, 9'h010, 16'h0000, 1'b0, 1'b1, 16'h2222};
    tbl[5] = '{1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h010, 16'h0000, 1'b1, 1'b1, 16'h1111};
    tbl[6] = '{1'b1, 1'b1, 9'h1FF, 16'hFFFF, 1'b1, 1'b0, 9'h1FF, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[7] = '{1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0, 9'h1FF, 16'h0000, 1'b1, 1'b1, 16'hFFFF};

    RST = 1'b1;
    drive_idle;
    #2;

    // Clear after reset with dirty memory; REQ0 raised during INIT waits for READY.
    hold_reset(1'b1);
    REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 9'h1FF;
    run_clear;
    step;
    chk("init_req_gnt0", 32'({GNT1, GNT0}), 32'b01);
    REQ0 = 1'b0;
    step;
    chk("init_req_ack0", 32'({ACK1, ACK0}), 32'b01);
    chk("read_511_after_clear", 32'(RDATA0), 32'd0);

    // Table-driven accesses: write/read-back across ports and alternating ties.
    hold_reset(1'b0);
    run_clear;
    for (int i = 0; i < 8; i++) begin
      REQ0 = tbl[i].r0; WE0 = tbl[i].w0; ADDR0 = tbl[i].a0; WDATA0 = tbl[i].d0;
      REQ1 = tbl[i].r1; WE1 = tbl[i].w1; ADDR1 = tbl[i].a1; WDATA1 = tbl[i].d1;
      step;
      chk($sformatf("vec%0d_gnt", i), 32'({GNT1, GNT0}), tbl[i].win ? 32'b10 : 32'b01);
      step;
      chk($sformatf("vec%0d_ack", i), 32'({ACK1, ACK0}), tbl[i].win ? 32'b10 : 32'b01);
      if (tbl[i].rd)
        chk($sformatf("vec%0d_rdata", i), 32'(tbl[i].win ? RDATA1 : RDATA0), 32'(tbl[i].rdata));
    end
    drive_idle;

    // Port 0 holds REQ continuously: one grant every other cycle, new command per grant.
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'h040; WDATA0 = 16'd5;
    idx = 0;
    bad = 0;
    for (int s = 1; s <= 20; s++) begin
      step;
      exp_g = (s % 2) == 1;
      if (GNT0 !== exp_g || ACK0 !== !exp_g || GNT1 !== 1'b0 || ACK1 !== 1'b0) bad++;
      if (GNT0 === 1'b1) begin
        idx++;
        ADDR0  = 9'h040 + 9'(idx);
        WDATA0 = 16'(idx * 3 + 5);
      end
    end
    REQ0 = 1'b0;
    chk("hold_pattern_bad", 32'(bad), 32'd0);
    chk("hold_grants", 32'(idx), 32'd10);
    bad = 0;
    for (int i = 0; i < 10; i++) if (mem[9'h040 + 9'(i)] !== 16'(i * 3 + 5)) bad++;
    chk("hold_mem_words_bad", 32'(bad), 32'd0);

    // Reset lands after the grant of a write but before its falling edge.
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'h041; WDATA0 = 16'h7777;
    step;
    chk("midrst_gnt0", 32'({GNT1, GNT0}), 32'b01);
    chk("midrst_mem_en", 32'(MEM_EN), 32'd1);
    RST = 1'b0;
    #1;
    check_all_zero("midrst");
    drive_idle;
    @(negedge CLK);
    #1;
    chk("midrst_word_kept", 32'(mem[9'h041]), 32'd8);
    hold_reset(1'b0);
    run_clear;

    // Random traffic against a transaction-level model of the arbitration rules.
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      m_rd[p] = '0; pend[p] = 1'b0; c_we[p] = 1'b0; c_addr[p] = '0; c_dat[p] = '0;
    end
    m_last = 1'b1;
    busy = 1'b0;
    prev_g = 2'b00;
    prev_read = 1'b0;
    prev_port = 1'b0;
    prev_val = '0;
    w = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_e0 = REQ0;
      req_e1 = REQ1;
      step;
      exp_gv = 2'b00;
      if (!busy && (req_e0 || req_e1)) begin
        w = (req_e0 && req_e1) ? ~m_last : req_e1;
        exp_gv = w ? 2'b10 : 2'b01;
      end
      chk("rnd_gnt", 32'({GNT1, GNT0}), 32'(exp_gv));
      chk("rnd_ack", 32'({ACK1, ACK0}), 32'(prev_g));
      if (prev_g != 2'b00 && prev_read) m_rd[prev_port] = prev_val;
      chk("rnd_rdata0", 32'(RDATA0), 32'(m_rd[0]));
      chk("rnd_rdata1", 32'(RDATA1), 32'(m_rd[1]));
      prev_g = exp_gv;
      busy = (exp_gv != 2'b00);
      if (busy) begin
        m_last = w;
        prev_port = w;
        if (c_we[w]) begin
          ref_mem[c_addr[w]] = c_dat[w];
          prev_read = 1'b0;
        end else begin
          prev_read = 1'b1;
          prev_val = ref_mem[c_addr[w]];
        end
        pend[w] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p]   = 1'b1;
          c_we[p]   = $urandom_range(0, 1) == 1;
          c_addr[p] = 9'($urandom_range(0, 7));
          c_dat[p]  = 16'($urandom);
        end
      end
      REQ0 = pend[0]; WE0 = c_we[0]; ADDR0 = c_addr[0]; WDATA0 = c_dat[0];
      REQ1 = pend[1]; WE1 = c_we[1]; ADDR1 = c_addr[1]; WDATA1 = c_dat[1];
    end
    drive_idle;
    step;
    step;
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("rnd_mem_final_bad", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
